// File: rtl/boot_frame_parser.sv
// Framed boot-image parser: pops bytes from a FWFT FIFO, checks length and checksum,
// and writes little-endian 32-bit words into instruction memory.
module boot_frame_parser #(
    parameter int unsigned IMEM_DEPTH     = 1024,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    input  logic [7:0]            fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [31:0]           imem_wr_data,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic                  imem_wr_en,
    output logic                  boot_done,
    output logic                  boot_error,
    output logic [1:0]            error_code,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [1:0]           lane_q, lane_d;
    logic [23:0]          shift_q, shift_d;
    logic [7:0]           sum_q, sum_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;

    logic        in_frame;
    logic        consume;
    logic [15:0] frame_len;
    logic        len_bad;
    logic [7:0]  sum_next;
    logic        last_word;
    logic        tmo_hit;

    assign in_frame  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign fifo_rd_en = !fifo_empty && ((state_q == ST_IDLE) || in_frame);
    assign consume   = fifo_rd_en;
    assign frame_len = {fifo_rd_data, len_lo_q};
    assign len_bad   = (frame_len == 16'd0) || (frame_len > 16'(IMEM_DEPTH));
    assign sum_next  = sum_q + fifo_rd_data;
    assign last_word = (idx_q == len_q - CNT_W'(1));
    // Timeout fires on the cycle the idle-gap counter would reach the limit.
    assign tmo_hit   = in_frame && !consume && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_IDLE:    if (consume && fifo_rd_data == SYNC_BYTE) state_d = ST_LEN_LO;
                ST_LEN_LO:  if (consume) state_d = ST_LEN_HI;
                ST_LEN_HI:  if (consume) state_d = len_bad ? ST_ERROR : ST_PAYLOAD;
                ST_PAYLOAD: if (consume && lane_q == 2'd3 && last_word) state_d = ST_CHECK;
                ST_CHECK:   if (consume) state_d = (sum_next == 8'h00) ? ST_DONE : ST_ERROR;
                default:    state_d = state_q;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        shift_d   = shift_q;
        sum_d     = sum_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;

        if (state_q == ST_IDLE) begin
            sum_d = 8'h00;
            tmo_d = '0;
        end else if (in_frame) begin
            tmo_d = consume ? '0 : tmo_q + TMO_W'(1);
        end

        if (tmo_hit) begin
            err_d  = 1'b1;
            code_d = ERR_TMO;
        end else if (consume) begin
            case (state_q)
                ST_LEN_LO: begin
                    len_lo_d = fifo_rd_data;
                    sum_d    = sum_next;
                end
                ST_LEN_HI: begin
                    sum_d  = sum_next;
                    len_d  = CNT_W'(frame_len);
                    idx_d  = '0;
                    lane_d = 2'd0;
                    if (len_bad) begin
                        err_d  = 1'b1;
                        code_d = ERR_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    sum_d  = sum_next;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q[ADDR_WIDTH-1:0];
                        wr_data_d = {fifo_rd_data, shift_q};
                        idx_d     = idx_q + CNT_W'(1);
                    end else begin
                        shift_d = {fifo_rd_data, shift_q[23:8]};
                    end
                end
                ST_CHECK: begin
                    if (sum_next == 8'h00) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            len_lo_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            lane_q    <= '0;
            shift_q   <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            shift_q   <= shift_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign boot_done    = done_q;
    assign boot_error   = err_q;
    assign error_code   = code_q;
    assign word_count   = idx_q;

endmodule

// File: tb/tb_boot_frame_parser.sv
// Bench for boot_frame_parser: FWFT FIFO driver, write scoreboard, stream-level reference model.
module tb_boot_frame_parser;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned TMO   = 100;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst_n = 1'b0;
    logic [7:0]    fifo_rd_data = 8'h00;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [31:0]   imem_wr_data;
    logic [AW-1:0] imem_wr_addr;
    logic          imem_wr_en;
    logic          boot_done;
    logic          boot_error;
    logic [1:0]    error_code;
    logic [AW:0]   word_count;

    boot_frame_parser #(
        .IMEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .imem_wr_data(imem_wr_data), .imem_wr_addr(imem_wr_addr), .imem_wr_en(imem_wr_en),
        .boot_done(boot_done), .boot_error(boot_error), .error_code(error_code),
        .word_count(word_count)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] tx_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cons_cyc = 0;
    int last_wr_cyc = -1;
    int consumed = 0;
    int stall_pct = 0;

    bit         exp_done, exp_err, exp_complete;
    logic [1:0] exp_code;
    int         exp_cnt, exp_used;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: walks the whole byte stream by the framing rules.
    task automatic model(input logic [7:0] s[$]);
        int i = 0;
        int n;
        int sum;
        exp_done = 0; exp_err = 0; exp_code = 2'b00; exp_cnt = 0; exp_complete = 0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        exp_used = s.size();
        if (i >= s.size()) return;
        i++;
        if (i + 2 > s.size()) return;
        n   = int'(s[i]) + 256 * int'(s[i+1]);
        sum = int'(s[i]) + int'(s[i+1]);
        i += 2;
        if (n == 0 || n > int'(DEPTH)) begin
            exp_err = 1; exp_code = 2'b01; exp_complete = 1; exp_used = i;
            return;
        end
        for (int w = 0; w < n; w++) begin
            wr_t e;
            if (i + 4 > s.size()) return;
            e.addr = AW'(w);
            e.data = {s[i+3], s[i+2], s[i+1], s[i]};
            sum += int'(s[i]) + int'(s[i+1]) + int'(s[i+2]) + int'(s[i+3]);
            exp_wr.push_back(e);
            exp_cnt++;
            i += 4;
        end
        if (i >= s.size()) return;
        sum += int'(s[i]);
        exp_complete = 1;
        exp_used = i + 1;
        if (sum % 256 == 0) exp_done = 1;
        else begin exp_err = 1; exp_code = 2'b10; end
    endtask

    task automatic cycle_counter();
        forever begin
            @(posedge cpu_clk);
            cyc++;
        end
    endtask

    // FWFT FIFO: presents head byte at negedge, pops when the DUT asserts rd_en.
    task automatic driver();
        forever begin
            @(negedge cpu_clk);
            if (tx_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
                fifo_empty   = 1'b0;
                fifo_rd_data = tx_q[0];
            end else begin
                fifo_empty   = 1'b1;
                fifo_rd_data = 8'($urandom);
            end
            #1;
            if (cpu_rst_n && fifo_rd_en && !fifo_empty) begin
                void'(tx_q.pop_front());
                consumed++;
                last_cons_cyc = cyc + 1;
            end
        end
    endtask

    task automatic monitor();
        logic prev_wr = 1'b0;
        forever begin
            @(negedge cpu_clk);
            #2;
            if (cpu_rst_n && imem_wr_en) begin
                last_wr_cyc = cyc;
                check("wr_single_cycle", 64'(prev_wr), 64'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(imem_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(imem_wr_data), 64'(e.data));
                end
            end
            prev_wr = imem_wr_en;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"},   64'(imem_wr_en),   64'd0);
        check({tag, "_wr_addr"}, 64'(imem_wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(imem_wr_data), 64'd0);
        check({tag, "_done"},    64'(boot_done),    64'd0);
        check({tag, "_error"},   64'(boot_error),   64'd0);
        check({tag, "_code"},    64'(error_code),   64'd0);
        check({tag, "_wcount"},  64'(word_count),   64'd0);
        check({tag, "_rd_en"},   64'(fifo_rd_en),   64'd0);
    endtask

    task automatic do_reset();
        tx_q.delete();
        exp_wr.delete();
        @(negedge cpu_clk);
        #3;
        cpu_rst_n = 1'b0;
        repeat (2) @(negedge cpu_clk);
        #3;
        check_zero_outputs("reset");
        cpu_rst_n = 1'b1;
        consumed = 0;
        last_wr_cyc = -1;
    endtask

    task automatic wait_result(output int t);
        int n = 0;
        while (!(boot_done || boot_error) && n < 2000) begin
            @(negedge cpu_clk);
            #3;
            n++;
        end
        if (n >= 2000) check("result_wait_expired", 64'd0, 64'd1);
        t = cyc;
    endtask

    task automatic run_stream(input logic [7:0] s_in[$], input int pct);
        logic [7:0] s[$];
        int t;
        s = s_in;
        s.push_back(8'($urandom));
        s.push_back(8'($urandom));
        model(s);
        stall_pct = pct;
        foreach (s[k]) tx_q.push_back(s[k]);
        wait_result(t);
        check("result_latency", 64'(t), 64'(last_cons_cyc));
        if (exp_done && exp_cnt > 0) check("write_before_done", 64'(t > last_wr_cyc), 64'd1);
        repeat (4) @(negedge cpu_clk);
        #3;
        check("boot_done",   64'(boot_done),  64'(exp_done));
        check("boot_error",  64'(boot_error), 64'(exp_err));
        check("error_code",  64'(error_code), 64'(exp_code));
        check("word_count",  64'(word_count), 64'(exp_cnt));
        check("writes_left", 64'(exp_wr.size()), 64'd0);
        check("unconsumed",  64'(tx_q.size()), 64'(s.size() - exp_used));
        check("rd_en_after", 64'(fifo_rd_en), 64'd0);
    endtask

    initial begin
        logic [7:0] f1[$]  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h93, 8'h00, 8'h10, 8'h00, 8'h48};
        logic [7:0] s[$];
        int t;
        int n;
        int wait_n;
        logic [7:0] sum;

        fork
            cycle_counter();
            driver();
            monitor();
        join_none

        do_reset();

        run_stream(f1, 0);
        do_reset();

        s = '{8'h00, 8'hFF, 8'h5A};
        foreach (f1[k]) s.push_back(f1[k]);
        run_stream(s, 0);
        do_reset();

        s = f1;
        s[s.size()-1] = 8'h49;
        run_stream(s, 0);
        do_reset();

        s = '{8'hA5, 8'h00, 8'h00};
        run_stream(s, 0);
        do_reset();
        s = '{8'hA5, 8'h01, 8'h04};
        run_stream(s, 0);
        do_reset();

        // Timeout: stream stops mid-payload
        s = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        model(s);
        stall_pct = 0;
        foreach (s[k]) tx_q.push_back(s[k]);
        wait_n = 0;
        while (consumed < 5 && wait_n < 100) begin
            @(negedge cpu_clk);
            wait_n++;
        end
        check("tmo_bytes_consumed", 64'(consumed), 64'd5);
        wait_result(t);
        check("tmo_latency", 64'(t - last_cons_cyc), 64'(TMO));
        check("tmo_error",   64'(boot_error), 64'd1);
        check("tmo_code",    64'(error_code), 64'd3);
        check("tmo_done",    64'(boot_done),  64'd0);
        check("tmo_wcount",  64'(word_count), 64'd0);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        repeat (10) @(negedge cpu_clk);
        #3;
        check("tmo_no_consume", 64'(tx_q.size()), 64'd3);
        check("tmo_rd_en", 64'(fifo_rd_en), 64'd0);
        do_reset();

        // Reset mid-payload, then a stalled valid frame
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        model(s);
        stall_pct = 30;
        foreach (s[k]) tx_q.push_back(s[k]);
        wait_n = 0;
        while (tx_q.size() > 0 && wait_n < 500) begin
            @(negedge cpu_clk);
            wait_n++;
        end
        repeat (3) @(negedge cpu_clk);
        check("midrst_first_write_seen", 64'(exp_wr.size()), 64'd0);
        check("midrst_wcount_before", 64'(word_count), 64'd1);
        #3;
        cpu_rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(negedge cpu_clk);
        #3;
        cpu_rst_n = 1'b1;
        consumed = 0;
        last_wr_cyc = -1;
        run_stream(f1, 30);
        do_reset();

        // Randomized frames: garbage prefix, random length, occasional bad length or checksum
        for (int it = 0; it < 20; it++) begin
            s.delete();
            for (int g = 0; g < int'($urandom_range(3)); g++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                s.push_back(b);
            end
            s.push_back(8'hA5);
            case ($urandom_range(9))
                0:       n = 0;
                1:       n = 1025 + int'($urandom_range(200));
                default: n = 1 + int'($urandom_range(5));
            endcase
            s.push_back(8'(n));
            s.push_back(8'(n >> 8));
            if (n >= 1 && n <= int'(DEPTH)) begin
                sum = 8'(n) + 8'(n >> 8);
                for (int k = 0; k < 4 * n; k++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    sum += b;
                    s.push_back(b);
                end
                sum = 8'h00 - sum;
                if ($urandom_range(3) == 0) sum += 8'(1 + $urandom_range(254));
                s.push_back(sum);
            end
            run_stream(s, 30);
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
